// File: rtl/edge_rate_meter_pkg.sv
// Shared constants and sizing helper for the edge rate meter and its siblings.
// Default gate window is one second of the 50 MHz board clock.
package edge_rate_meter_pkg;

  localparam int GATE_CYCLES_1S = 50_000_000;
  localparam int COUNT_W_DEF    = 16;

  // Bits needed to hold 0..value-1; a single-state counter still gets one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/edge_rate_meter_if.sv
// Signal bundle between the edge rate meter and its surroundings.
// slave = the meter (consumes D16_i, drives results); master = the environment.
interface edge_rate_meter_if
  import edge_rate_meter_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) ();

  logic               D16_i;
  logic [COUNT_W-1:0] rate_count;
  logic               rate_valid;
  logic               rate_ovf;
  logic               edge_pulse;
  logic               LED_D9, LED_D8, LED_D7, LED_D6;
  logic               LED_D5, LED_D4, LED_D3, LED_D2;

  modport slave (
    input  D16_i,
    output rate_count, rate_valid, rate_ovf, edge_pulse,
    output LED_D9, LED_D8, LED_D7, LED_D6, LED_D5, LED_D4, LED_D3, LED_D2
  );

  modport master (
    output D16_i,
    input  rate_count, rate_valid, rate_ovf, edge_pulse,
    input  LED_D9, LED_D8, LED_D7, LED_D6, LED_D5, LED_D4, LED_D3, LED_D2
  );

endinterface

// File: rtl/edge_rate_meter_sync_rise_detect.sv
// 2-FF synchroniser plus one history flop; rise_o is a glitch-free one-cycle pulse.
// Latency: input captured at clock k shows on rise_o after clock k+1; no backpressure.
module sync_rise_detect (
  input  logic CLK_IN,
  input  logic RST_IN,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= async_i;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s1 may be metastable, so only r_s2/r_s3 feed logic.
  assign level_o = r_s2;
  assign rise_o  = r_s2 & ~r_s3;

endmodule

// File: rtl/edge_rate_meter.sv
// Counts rising edges of D16_i per GATE_CYCLES window, latches the count, drives LEDs.
// Latency: edge to rate_count <= GATE_CYCLES+3 clocks; free-running, no backpressure.
module edge_rate_meter
  import edge_rate_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_1S,
  parameter int COUNT_W     = COUNT_W_DEF,
  parameter int LED_LSB     = 8
) (
  input  logic              CLK_IN,
  input  logic              RST_IN,
  edge_rate_meter_if.slave  bus
);

  localparam int               GW        = clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [GW-1:0]      r_gate_cnt;
  logic [COUNT_W-1:0] r_edge_cnt;
  logic               r_ovf_acc;
  logic [COUNT_W-1:0] r_rate_count;
  logic               r_rate_valid;
  logic               r_rate_ovf;

  logic               w_rise;
  logic               w_level_unused;
  logic               w_tc;
  logic               w_at_max;
  logic [7:0]         w_led;

  sync_rise_detect u_sync (
    .CLK_IN  (CLK_IN),
    .RST_IN  (RST_IN),
    .async_i (bus.D16_i),
    .level_o (w_level_unused),
    .rise_o  (w_rise)
  );

  assign w_tc     = (r_gate_cnt == GATE_LAST);
  assign w_at_max = (r_edge_cnt == CNT_MAX);

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_ovf_acc    <= 1'b0;
      r_rate_count <= '0;
      r_rate_valid <= 1'b0;
      r_rate_ovf   <= 1'b0;
    end else begin
      r_rate_valid <= w_tc;
      if (w_tc) begin
        // An edge on the terminal cycle closes out with this window.
        r_gate_cnt   <= '0;
        r_rate_count <= (w_rise && !w_at_max) ? r_edge_cnt + 1'b1 : r_edge_cnt;
        r_rate_ovf   <= r_ovf_acc | (w_rise & w_at_max);
        r_edge_cnt   <= '0;
        r_ovf_acc    <= 1'b0;
      end else begin
        r_gate_cnt <= r_gate_cnt + 1'b1;
        if (w_rise) begin
          if (w_at_max) r_ovf_acc  <= 1'b1;
          else          r_edge_cnt <= r_edge_cnt + 1'b1;
        end
      end
    end
  end

  // Zero-extend so narrow counters still map cleanly onto the 8 LEDs.
  assign w_led = 8'({8'd0, r_rate_count} >> LED_LSB);

  assign bus.rate_count = r_rate_count;
  assign bus.rate_valid = r_rate_valid;
  assign bus.rate_ovf   = r_rate_ovf;
  assign bus.edge_pulse = w_rise;
  assign bus.LED_D9     = w_led[7];
  assign bus.LED_D8     = w_led[6];
  assign bus.LED_D7     = w_led[5];
  assign bus.LED_D6     = w_led[4];
  assign bus.LED_D5     = w_led[3];
  assign bus.LED_D4     = w_led[2];
  assign bus.LED_D3     = w_led[1];
  assign bus.LED_D2     = w_led[0];

endmodule

// File: tb/tb_edge_rate_meter.sv
// Directed bench: 16-cycle gate, one 8-bit meter and one 3-bit meter sharing the input.
module tb_edge_rate_meter;

  logic CLK_IN = 1'b0;
  logic RST_IN = 1'b1;
  logic d_in   = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  edge_rate_meter_if #(.COUNT_W(8)) bus_a ();
  edge_rate_meter_if #(.COUNT_W(3)) bus_b ();

  assign bus_a.D16_i = d_in;
  assign bus_b.D16_i = d_in;

  edge_rate_meter #(.GATE_CYCLES(16), .COUNT_W(8), .LED_LSB(0)) dut_a (
    .CLK_IN (CLK_IN), .RST_IN (RST_IN), .bus (bus_a.slave)
  );
  edge_rate_meter #(.GATE_CYCLES(16), .COUNT_W(3), .LED_LSB(0)) dut_b (
    .CLK_IN (CLK_IN), .RST_IN (RST_IN), .bus (bus_b.slave)
  );

  wire [7:0] leds_a = {bus_a.LED_D9, bus_a.LED_D8, bus_a.LED_D7, bus_a.LED_D6,
                       bus_a.LED_D5, bus_a.LED_D4, bus_a.LED_D3, bus_a.LED_D2};
  wire [7:0] leds_b = {bus_b.LED_D9, bus_b.LED_D8, bus_b.LED_D7, bus_b.LED_D6,
                       bus_b.LED_D5, bus_b.LED_D4, bus_b.LED_D3, bus_b.LED_D2};

  always #5 CLK_IN = ~CLK_IN;

  // cyc = number of clocks since reset release; sampling is 1 ns after the edge.
  task automatic tick();
    @(posedge CLK_IN);
    #1;
    if (!RST_IN) cyc = cyc + 1;
  endtask

  task automatic test_reset();
    RST_IN = 1'b1;
    d_in   = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus_a.rate_count, bus_a.rate_valid, bus_a.rate_ovf, bus_a.edge_pulse, leds_a} !== '0) begin
      failures++;
      $display("FAIL reset_a got cnt=%0d vld=%b ovf=%b pulse=%b led=%h exp all 0",
               bus_a.rate_count, bus_a.rate_valid, bus_a.rate_ovf, bus_a.edge_pulse, leds_a);
    end
    checks++;
    if ({bus_b.rate_count, bus_b.rate_valid, bus_b.rate_ovf, bus_b.edge_pulse, leds_b} !== '0) begin
      failures++;
      $display("FAIL reset_b got cnt=%0d vld=%b ovf=%b pulse=%b led=%h exp all 0",
               bus_b.rate_count, bus_b.rate_valid, bus_b.rate_ovf, bus_b.edge_pulse, leds_b);
    end
    #2 RST_IN = 1'b0;
    cyc = 0;
  endtask

  task automatic test_quiet();
    for (int i = 0; i < 48; i++) begin
      tick();
      checks++;
      if (bus_a.rate_valid !== ((cyc % 16) == 0)) begin
        failures++;
        $display("FAIL quiet_strobe cyc=%0d got=%b exp=%b", cyc, bus_a.rate_valid, ((cyc % 16) == 0));
      end
      if ((cyc % 16) == 0) begin
        checks++;
        if (bus_a.rate_count !== 8'd0 || bus_a.rate_ovf !== 1'b0 || leds_a !== 8'h00 ||
            bus_b.rate_count !== 3'd0 || bus_b.rate_ovf !== 1'b0) begin
          failures++;
          $display("FAIL quiet_count cyc=%0d got a=%0d/%b led=%h b=%0d/%b exp 0/0 led=00 0/0",
                   cyc, bus_a.rate_count, bus_a.rate_ovf, leds_a, bus_b.rate_count, bus_b.rate_ovf);
        end
      end
    end
  endtask

  task automatic test_square4();
    int pc = 0;
    for (int r = 0; r < 80; r++) begin
      tick();
      if ((cyc % 16) == 0) begin
        if (r >= 20) begin
          checks++;
          if (bus_a.rate_valid !== 1'b1 || bus_a.rate_count !== 8'd4 || bus_a.rate_ovf !== 1'b0 ||
              leds_a !== 8'h04 || bus_b.rate_count !== 3'd4 || bus_b.rate_ovf !== 1'b0) begin
            failures++;
            $display("FAIL square4 cyc=%0d got vld=%b a=%0d/%b led=%h b=%0d/%b exp 1 4/0 04 4/0",
                     cyc, bus_a.rate_valid, bus_a.rate_count, bus_a.rate_ovf, leds_a,
                     bus_b.rate_count, bus_b.rate_ovf);
          end
          checks++;
          if (pc != 4) begin
            failures++;
            $display("FAIL square4_pulses cyc=%0d got=%0d exp=4", cyc, pc);
          end
        end
        pc = 0;
      end
      if (bus_a.edge_pulse === 1'b1) pc++;
      #($urandom_range(0, 3));
      d_in = ((r % 4) < 2);
    end
  endtask

  task automatic test_reset_mid();
    d_in = 1'b0;
    for (int i = 0; i < 16 && (cyc % 16) != 9; i++) tick();
    checks++;
    if (bus_a.rate_count !== 8'd4) begin
      failures++;
      $display("FAIL midrst_pre got=%0d exp=4", bus_a.rate_count);
    end
    #2 RST_IN = 1'b1;
    #1;
    checks++;
    if ({bus_a.rate_count, bus_a.rate_valid, bus_a.rate_ovf, leds_a, bus_b.rate_count} !== '0) begin
      failures++;
      $display("FAIL midrst_clear got a=%0d vld=%b ovf=%b led=%h b=%0d exp all 0",
               bus_a.rate_count, bus_a.rate_valid, bus_a.rate_ovf, leds_a, bus_b.rate_count);
    end
    repeat (3) begin
      tick();
      checks++;
      if (bus_a.rate_valid !== 1'b0 || bus_a.rate_count !== 8'd0) begin
        failures++;
        $display("FAIL midrst_hold got vld=%b cnt=%0d exp 0 0", bus_a.rate_valid, bus_a.rate_count);
      end
    end
    #2 RST_IN = 1'b0;
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (bus_a.rate_valid !== (cyc == 16)) begin
        failures++;
        $display("FAIL midrst_strobe cyc=%0d got=%b exp=%b", cyc, bus_a.rate_valid, (cyc == 16));
      end
    end
    checks++;
    if (bus_a.rate_count !== 8'd0 || bus_a.rate_ovf !== 1'b0) begin
      failures++;
      $display("FAIL midrst_count got=%0d/%b exp=0/0", bus_a.rate_count, bus_a.rate_ovf);
    end
  endtask

  task automatic test_toggle_saturate();
    for (int r = 0; r < 64; r++) begin
      tick();
      if ((cyc % 16) == 0 && r >= 20) begin
        checks++;
        if (bus_a.rate_count !== 8'd8 || bus_a.rate_ovf !== 1'b0 || leds_a !== 8'h08) begin
          failures++;
          $display("FAIL toggle_a cyc=%0d got=%0d/%b led=%h exp=8/0 led=08",
                   cyc, bus_a.rate_count, bus_a.rate_ovf, leds_a);
        end
        checks++;
        if (bus_b.rate_count !== 3'd7 || bus_b.rate_ovf !== 1'b1 || leds_b !== 8'h07) begin
          failures++;
          $display("FAIL sat_b cyc=%0d got=%0d/%b led=%h exp=7/1 led=07",
                   cyc, bus_b.rate_count, bus_b.rate_ovf, leds_b);
        end
      end
      d_in = ((r % 2) == 0);
    end
    d_in = 1'b0;
    for (int q = 0; q < 40; q++) begin
      tick();
      if ((cyc % 16) == 0 && q >= 20) begin
        checks++;
        if (bus_a.rate_count !== 8'd0 || bus_b.rate_count !== 3'd0 || bus_b.rate_ovf !== 1'b0) begin
          failures++;
          $display("FAIL sat_recover cyc=%0d got a=%0d b=%0d/%b exp 0 0/0",
                   cyc, bus_a.rate_count, bus_b.rate_count, bus_b.rate_ovf);
        end
      end
    end
  endtask

  task automatic test_tc_edge();
    for (int i = 0; i < 16 && (cyc % 16) != 13; i++) tick();
    d_in = 1'b1;
    tick();
    tick();
    checks++;
    if (bus_a.edge_pulse !== 1'b1 || (cyc % 16) != 15) begin
      failures++;
      $display("FAIL tc_pulse cyc=%0d got=%b exp=1", cyc, bus_a.edge_pulse);
    end
    tick();
    checks++;
    if (bus_a.rate_valid !== 1'b1 || bus_a.rate_count !== 8'd1 || bus_b.rate_count !== 3'd1 ||
        bus_a.edge_pulse !== 1'b0) begin
      failures++;
      $display("FAIL tc_close got vld=%b a=%0d b=%0d pulse=%b exp 1 1 1 0",
               bus_a.rate_valid, bus_a.rate_count, bus_b.rate_count, bus_a.edge_pulse);
    end
    repeat (16) tick();
    checks++;
    if (bus_a.rate_valid !== 1'b1 || bus_a.rate_count !== 8'd0) begin
      failures++;
      $display("FAIL tc_next got vld=%b cnt=%0d exp 1 0", bus_a.rate_valid, bus_a.rate_count);
    end
    d_in = 1'b0;
  endtask

  task automatic test_narrow_pulses();
    int pc = 0;
    int gen = 0;
    logic prev = 1'b0;
    for (int r = 0; r < 55; r++) begin
      tick();
      if (bus_a.edge_pulse === 1'b1) pc++;
      d_in = (r < 50) && ((r % 5) == 0);
    end
    checks++;
    if (pc != 10) begin
      failures++;
      $display("FAIL wide1_pulses got=%0d exp=10", pc);
    end
    pc = 0;
    for (int r = 0; r < 63; r++) begin
      tick();
      checks++;
      if (prev === 1'b1 && bus_a.edge_pulse === 1'b1) begin
        failures++;
        $display("FAIL narrow_double cyc=%0d got pulse on consecutive cycles exp isolated", cyc);
      end
      prev = bus_a.edge_pulse;
      if (bus_a.edge_pulse === 1'b1) pc++;
      if (d_in) begin
        d_in = 1'b0;
      end else if (r < 60) begin
        case ($urandom_range(0, 2))
          0: begin #7; d_in = 1'b1; gen++; end
          1: begin #3; d_in = 1'b1; #2; d_in = 1'b0; gen++; end
          default: ;
        endcase
      end
    end
    checks++;
    if (pc > gen) begin
      failures++;
      $display("FAIL narrow_count got=%0d exp<=%0d", pc, gen);
    end
  endtask

  initial begin
    test_reset();
    test_quiet();
    test_square4();
    test_reset_mid();
    test_toggle_saturate();
    test_tc_edge();
    test_narrow_pulses();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
